// File: rtl/serial_adder16_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_adder16_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder16_adder4_bit.sv
// Purely combinational 4-bit adder slice used once per nibble by serial_adder16.
module adder4_bit
   import serial_adder16_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                carryIn,
   output logic [NIBBLE_W-1:0] sum,
   output logic                carryOut
);

   logic [NIBBLE_W:0] total;

   assign total    = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, carryIn};
   assign sum      = total[NIBBLE_W-1:0];
   assign carryOut = total[NIBBLE_W];

endmodule

// File: rtl/serial_adder16.sv
// Nibble-serial WIDTH-bit adder with valid/ready handshakes on both sides.
module serial_adder16
   import serial_adder16_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   input  logic [WIDTH-1:0] io_a,
   input  logic [WIDTH-1:0] io_b,
   input  logic             io_carryIn,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   output logic [WIDTH-1:0] io_sum,
   output logic             io_carryOut
);

   localparam int NNIB  = WIDTH / NIBBLE_W;
   localparam int CNT_W = $clog2(NNIB);
   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

   state_t state, state_nxt;

   logic [WIDTH-1:0]    a_q, b_q, sum_q;
   logic                carry_q, cout_q;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    bit_lo;
   logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
   logic                nib_cout;
   logic                accept, last_nib;

   assign bit_lo   = {cnt, 2'b00};
   assign nib_a    = a_q[bit_lo +: NIBBLE_W];
   assign nib_b    = b_q[bit_lo +: NIBBLE_W];
   assign accept   = io_in_valid & io_in_ready;
   assign last_nib = (cnt == LAST_NIB);

   adder4_bit u_adder4 (
      .a        (nib_a),
      .b        (nib_b),
      .carryIn  (carry_q),
      .sum      (nib_sum),
      .carryOut (nib_cout)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      case (state)
         IDLE: begin
            io_in_ready = 1'b1;
            if (io_in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last_nib) state_nxt = DONE;
         end
         DONE: begin
            io_out_valid = 1'b1;
            if (io_out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operands are captured only on accept so input changes during RUN are ignored.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else if (accept) begin
         a_q     <= io_a;
         b_q     <= io_b;
         carry_q <= io_carryIn;
         cnt     <= '0;
      end else if (state == RUN) begin
         sum_q[bit_lo +: NIBBLE_W] <= nib_sum;
         carry_q                   <= nib_cout;
         if (last_nib) cout_q <= nib_cout;
         else          cnt    <= cnt + 1'b1;
      end
   end

   assign io_sum      = sum_q;
   assign io_carryOut = cout_q;

endmodule

// File: doc/serial_adder16.md
SERIAL_ADDER16 -- requirements
Module: serial_adder16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; must be a multiple of 4 and at least 8.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port io_in_valid, input, 1, upstream operands valid.
REQ-005 SHALL have port io_in_ready, output, 1, block can accept operands.
REQ-006 SHALL have ports io_a and io_b, input, WIDTH, addend operands.
REQ-007 SHALL have port io_carryIn, input, 1, carry into bit 0.
REQ-008 SHALL have port io_out_valid, output, 1, result valid.
REQ-009 SHALL have port io_out_ready, input, 1, downstream accepts result.
REQ-010 SHALL have port io_sum, output, WIDTH, registered sum.
REQ-011 SHALL have port io_carryOut, output, 1, registered carry out of bit WIDTH-1.

Function
REQ-012 SHALL compute {io_carryOut, io_sum} = io_a + io_b + io_carryIn, exact modulo 2^(WIDTH+1).
REQ-013 SHALL compute serially, one 4-bit nibble per cycle, least significant nibble first, using one 4-bit adder instance.
REQ-014 SHALL implement states IDLE, RUN, DONE.
REQ-015 SHALL drive io_in_ready = 1 only in IDLE.
REQ-016 SHALL, on an input handshake (io_in_valid & io_in_ready at the clock edge), latch io_a, io_b, and io_carryIn into the carry register, clear the nibble counter to 0, and enter RUN.
REQ-017 SHALL, in each RUN cycle k, add nibble k of the latched a and b plus the carry register.
REQ-018 In each RUN cycle k, SHALL write the 4-bit result into sum bits [4k+3:4k], load the carry register with the adder carry out, and increment k.
REQ-019 SHALL, in the RUN cycle with k = WIDTH/4-1, transition to DONE.
REQ-020 SHALL, on that same transition, register the final carry as io_carryOut.
REQ-021 SHALL drive io_out_valid = 1 only in DONE; io_out_valid rises exactly WIDTH/4 clock edges after the input handshake edge (4 for the default).
REQ-022 SHALL hold io_sum and io_carryOut stable while io_out_valid = 1 and io_out_ready = 0, indefinitely.
REQ-023 SHALL, on an output handshake in DONE, return to IDLE.
REQ-024 SHALL NOT accept new operands in the output-handshake cycle; the next accept is no earlier than the following cycle (throughput: one result per WIDTH/4+2 cycles).
REQ-025 SHALL ignore io_in_valid, io_a, io_b and io_carryIn outside IDLE; operand changes during RUN do not affect the result.
REQ-026 SHALL keep io_sum and io_carryOut at their last values in IDLE until the next computation overwrites them.
REQ-027 SHALL keep the nibble counter log2(WIDTH/4) bits wide with no wrap beyond WIDTH/4-1.

Reset
REQ-028 SHALL, on reset low at any time including mid-RUN or in DONE, immediately enter IDLE.
REQ-029 On reset low, SHALL force io_out_valid = 0, io_in_ready = 1, io_sum = 0, io_carryOut = 0, carry register = 0, counter = 0 and operand registers = 0.
REQ-030 SHALL abandon a computation interrupted by reset, with no output produced for it.
REQ-031 SHALL, on reset deassertion, accept operands on the first clock edge with io_in_valid = 1.

Structure
REQ-032 SHALL place the state enumeration (IDLE, RUN, DONE) and constant NIBBLE_W = 4 in a shared package.
REQ-033 SHALL instantiate exactly one sub-module, adder4_bit: 4-bit a, b, carryIn in; 4-bit sum and carryOut out; purely combinational.
REQ-034 SHALL keep all registers in serial_adder16; adder4_bit contains no state.

Verification
REQ-035 Bench SHALL apply a=0x1234, b=0x4321, cin=0 -> sum=0x5555, carryOut=0, with io_out_valid high exactly 4 edges after accept.
REQ-036 Bench SHALL apply a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carryOut=1, exercising the carry ripple across all nibbles.
REQ-037 Bench SHALL apply a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, carryOut=1.
REQ-038 Bench SHALL apply a=0x00F0, b=0x0010, cin=0 with io_out_ready held low 5 cycles -> io_out_valid held high and sum=0x0100 stable throughout; io_in_ready low until one cycle after the output handshake.
REQ-039 Bench SHALL assert reset low during RUN at k=2 -> next cycle state IDLE, io_sum=0, io_out_valid=0, io_in_ready=1.
REQ-040 After that reset, bench SHALL apply a=0x0001, b=0x0002, cin=0 -> sum=0x0003.
REQ-041 Bench SHALL check 1000 random operand triples with random valid/ready stalls against the reference a+b+cin.
